rv32i_core: RTL and testbench
=============================

RV32I_CORE -- requirements
Module: rv32i_core

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, depth of unified instruction/data memory in 32-bit words (power of two).
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL contain memory array named mem, [31:0] x MEM_WORDS, loadable by $readmemh; word index 0 holds the instruction at RESET_PC.
REQ-006 SHALL contain register-file instance i_regfile with array data[0:31] of 32-bit registers, hierarchically accessible.
REQ-007 SHALL contain 1-bit internal signal is_ecall, hierarchically accessible.

Function
REQ-008 SHALL execute the full RV32I base ISA (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP), one instruction per clock, single-cycle, no pipeline.
REQ-009 SHALL map any byte address A to mem[A[log2(MEM_WORDS)+1:2]]; upper address bits ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-010 SHALL read instruction and load data combinationally; stores and register writes commit on the rising clk edge ending the instruction.
REQ-011 SHALL keep data[0] reading 0; writes to x0 discarded.
REQ-012 SHALL implement LB/LH sign-extension and LBU/LHU zero-extension, selecting byte/halfword lanes by A[1:0]; SB/SH modify only addressed lanes.
REQ-013 SHALL align misaligned accesses down: halfword uses A[1] only, word ignores A[1:0]; no exception raised.
REQ-014 SHALL compute arithmetic modulo 2^32; shifts use rs2[4:0]/shamt; SLT/SLTI signed, SLTU/SLTIU unsigned.
REQ-015 SHALL write rd=PC+4 for JAL/JALR; JALR target=(rs1+imm)&~1; when rd==rs1, target uses the old rs1.
REQ-016 SHALL set is_ecall=1 combinationally while the instruction at PC is ECALL (32'h0000_0073); PC and all state then hold until reset.
REQ-017 SHALL treat FENCE, FENCE.I, EBREAK, MRET and undecoded opcodes as NOP (PC+4, no writes).
REQ-018 SHALL treat CSR instructions (CSRRW/S/C, CSRRWI/SI/CI) as writing 0 to rd with no other side effect.
REQ-019 SHALL update PC to PC+4 unless a taken branch/jump or ECALL; branch target = PC+B-imm.

Reset
REQ-020 SHALL, while rst=1, set PC=RESET_PC asynchronously and suppress all register and memory writes.
REQ-021 SHALL NOT reset mem or i_regfile.data[1..31]; contents persist across reset.
REQ-022 SHALL leave is_ecall defined only by the instruction at PC; after reset it reflects mem[0].
REQ-023 SHALL start execution at the first rising clk edge after rst deasserts; reset mid-instruction discards that instruction's writes.

Configuration
REQ-024 SHALL, with macro RV32I_CORE_HALT_EN defined, add port halt input 1; halt=1 freezes PC and suppresses register/memory writes, resuming unchanged on halt=0.
REQ-025 SHALL, without RV32I_CORE_HALT_EN, have no halt port and always execute.

Verification
REQ-026 ADDI x3,x0,1 then ECALL at mem[0..1]; release reset -> after 2 clocks is_ecall=1, data[3]=1, PC=0x8000_0004 held.
REQ-027 LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,0x100(x0); LB x2,0x101(x0); LBU x4,0x103(x0) -> mem[64]=0x1234_5678, x2=0x56, x4=0x12.
REQ-028 ADDI x1,x0,-1; SLTU x2,x0,x1; SLT x3,x1,x0; SRAI x4,x1,4 -> x2=1, x3=1, x4=0xFFFF_FFFF.
REQ-029 BEQ x0,x0,+8 skipping ADDI x3,x0,2; JAL x5,+8 -> x3 unchanged, x5=PC_of_JAL+4; ADDI x0,x0,5 -> x0 reads 0.
REQ-030 Assert rst for one clock mid-program -> PC returns to 0x8000_0000, registers and mem retain prior values; with RV32I_CORE_HALT_EN, halt=1 for 5 clocks -> PC unchanged, no writes.

Source files
------------

// File: rtl/rv32i_core.sv
// rtl/rv32i_core.sv - single-cycle RV32I core with unified word memory; optional halt input via RV32I_CORE_HALT_EN

module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] data [0:31];

  // x0 is pinned to zero by reset and never written; x1..x31 keep contents across reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data[0] <= '0;
    else if (we && waddr != 5'd0) data[waddr] <= wdata;
  end

  // read ports force x0 to zero independently of array contents
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : data[raddr1];
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : data[raddr2];
  end
endmodule

module rv32i_core #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
  input  logic clk,
`ifdef RV32I_CORE_HALT_EN
  input  logic halt,
`endif
  input  logic rst
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BR = 7'h63, OPC_LD = 7'h03, OPC_ST = 7'h23, OPC_OPI = 7'h13;
  localparam logic [6:0] OPC_OP = 7'h33, OPC_SYS = 7'h73;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] pc, pc_next, instr;
  logic        is_ecall, run;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] op_b, alu, ld_addr, st_addr, ld_word, ld_shift;
  logic [15:0] ld_half;
  logic        taken, rd_we, mem_we;
  logic [31:0] rd_wdata, mem_wdata;
  logic [3:0]  mem_mask;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

`ifdef RV32I_CORE_HALT_EN
  assign run = ~halt;
`else
  assign run = 1'b1;
`endif

  assign instr   = mem[pc[AW+1:2]];
  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'd0};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign ld_addr = rs1_val + imm_i;
  assign st_addr = rs1_val + imm_s;
  assign ld_word = mem[ld_addr[AW+1:2]];
  assign ld_shift = ld_word >> {ld_addr[1:0], 3'b000};
  assign ld_half  = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];

  logic unused_bits;
  assign unused_bits = ^{ld_addr[31:AW+2], st_addr[31:AW+2], st_addr[1:0], pc[1:0], pc[31:AW+2]};

  rv32i_regfile i_regfile (
    .clk(clk), .rst(rst), .we(rd_we & run), .waddr(instr[11:7]), .wdata(rd_wdata),
    .raddr1(instr[19:15]), .raddr2(instr[24:20]), .rdata1(rs1_val), .rdata2(rs2_val)
  );

  // shared ALU for OP and OP-IMM; SUB only exists in the register form
  always_comb begin
    op_b = (opcode == OPC_OP) ? rs2_val : imm_i;
    unique case (funct3)
      3'b000:  alu = (opcode == OPC_OP && instr[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu = rs1_val << op_b[4:0];
      3'b010:  alu = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011:  alu = {31'd0, rs1_val < op_b};
      3'b100:  alu = rs1_val ^ op_b;
      3'b101:  alu = instr[30] ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110:  alu = rs1_val | op_b;
      default: alu = rs1_val & op_b;
    endcase
  end

  // branch condition; reserved funct3 codes never branch
  always_comb begin
    case (funct3)
      3'b000:  taken = rs1_val == rs2_val;
      3'b001:  taken = rs1_val != rs2_val;
      3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  taken = rs1_val <  rs2_val;
      3'b111:  taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  // instruction decode: next PC, register write and store lanes; anything unknown falls through as NOP
  always_comb begin
    pc_next   = pc + 32'd4;
    rd_we     = 1'b0;
    rd_wdata  = 32'd0;
    mem_we    = 1'b0;
    mem_mask  = 4'b0000;
    mem_wdata = 32'd0;
    is_ecall  = 1'b0;
    case (opcode)
      OPC_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OPC_AUIPC: begin rd_we = 1'b1; rd_wdata = pc + imm_u; end
      OPC_JAL:   begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = pc + imm_j; end
      OPC_JALR:  begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = ld_addr & ~32'd1; end
      OPC_BR:    if (taken) pc_next = pc + imm_b;
      OPC_OPI, OPC_OP: begin rd_we = 1'b1; rd_wdata = alu; end
      OPC_LD: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_wdata = {{24{ld_shift[7]}}, ld_shift[7:0]};
          3'b001:  rd_wdata = {{16{ld_half[15]}}, ld_half};
          3'b010:  rd_wdata = ld_word;
          3'b100:  rd_wdata = {24'd0, ld_shift[7:0]};
          3'b101:  rd_wdata = {16'd0, ld_half};
          default: rd_we = 1'b0;
        endcase
      end
      OPC_ST: begin
        mem_we = 1'b1;
        case (funct3)
          3'b000:  begin mem_wdata = {4{rs2_val[7:0]}};  mem_mask = 4'b0001 << st_addr[1:0]; end
          3'b001:  begin mem_wdata = {2{rs2_val[15:0]}}; mem_mask = st_addr[1] ? 4'b1100 : 4'b0011; end
          3'b010:  begin mem_wdata = rs2_val;            mem_mask = 4'b1111; end
          default: mem_we = 1'b0;
        endcase
      end
      OPC_SYS: begin
        if (instr == 32'h0000_0073) begin
          is_ecall = 1'b1;
          pc_next  = pc;
        end else if (funct3 != 3'b000) begin
          rd_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // program counter; reset wins asynchronously, halt freezes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else if (run) pc <= pc_next;
  end

  // byte-lane store commit; suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && run && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_mask[i]) mem[st_addr[AW+1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_rv32i_core.sv
// tb/tb_rv32i_core.sv - directed self-checking bench for rv32i_core

module tb_rv32i_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef RV32I_CORE_HALT_EN
  logic halt = 1'b0;
`endif
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prog [$];

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  always #5 clk = ~clk;

  rv32i_core #(.MEM_WORDS(16384), .RESET_PC(RPC)) dut (
    .clk(clk),
`ifdef RV32I_CORE_HALT_EN
    .halt(halt),
`endif
    .rst(rst)
  );

  function automatic logic [31:0] op_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] op_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] op_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] op_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] op_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] op_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // hold reset, fill low memory with ECALL, load prog, release reset on a falling edge
  task automatic start();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.mem[i] = ECALL;
    foreach (prog[i]) dut.mem[i] = prog[i];
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_ecall(input int max_cycles);
    int n = 0;
    while (!dut.is_ecall && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("ecall_reached", {31'd0, dut.is_ecall}, 32'd1);
  endtask

  initial begin
    // ADDI then ECALL
    prog = {op_i(32'd1, 5'd0, 3'b000, 5'd3, 7'h13), ECALL};
    start();
    chk("reset_pc", dut.pc, RPC);
    chk("reset_ecall", {31'd0, dut.is_ecall}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_ecall", {31'd0, dut.is_ecall}, 32'd1);
    chk("t1_x3", dut.i_regfile.data[3], 32'd1);
    chk("t1_pc", dut.pc, 32'h8000_0004);
    repeat (3) @(negedge clk);
    chk("t1_pc_held", dut.pc, 32'h8000_0004);

    // loads/stores with lane selection and misalignment
    prog = {op_u(20'h12345, 5'd1, 7'h37),
            op_i(32'h678, 5'd1, 3'b000, 5'd1, 7'h13),
            op_s(32'h100, 5'd1, 5'd0, 3'b010),
            op_i(32'h101, 5'd0, 3'b000, 5'd2, 7'h03),
            op_i(32'h103, 5'd0, 3'b100, 5'd4, 7'h03),
            op_i(32'h102, 5'd0, 3'b001, 5'd5, 7'h03),
            op_i(32'hFFFF_FF80, 5'd0, 3'b000, 5'd6, 7'h13),
            op_s(32'h102, 5'd6, 5'd0, 3'b000),
            op_i(32'h102, 5'd0, 3'b000, 5'd7, 7'h03),
            op_i(32'h103, 5'd0, 3'b101, 5'd8, 7'h03),
            op_s(32'h100, 5'd6, 5'd0, 3'b001),
            op_i(32'h101, 5'd0, 3'b001, 5'd9, 7'h03),
            op_i(32'h103, 5'd0, 3'b010, 5'd10, 7'h03),
            ECALL};
    start();
    run_to_ecall(50);
    chk("t2_mem64", dut.mem[64], 32'h1280_FF80);
    chk("t2_lb", dut.i_regfile.data[2], 32'h0000_0056);
    chk("t2_lbu", dut.i_regfile.data[4], 32'h0000_0012);
    chk("t2_lh", dut.i_regfile.data[5], 32'h0000_1234);
    chk("t2_lb_neg", dut.i_regfile.data[7], 32'hFFFF_FF80);
    chk("t2_lhu_mis", dut.i_regfile.data[8], 32'h0000_1280);
    chk("t2_lh_neg", dut.i_regfile.data[9], 32'hFFFF_FF80);
    chk("t2_lw_mis", dut.i_regfile.data[10], 32'h1280_FF80);

    // arithmetic, compares and shifts
    prog = {op_i(32'hFFF, 5'd0, 3'b000, 5'd1, 7'h13),
            op_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd2),
            op_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd3),
            op_i(32'h404, 5'd1, 3'b101, 5'd4, 7'h13),
            op_i(32'h004, 5'd1, 3'b101, 5'd5, 7'h13),
            op_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd6),
            op_i(32'h01F, 5'd1, 3'b001, 5'd7, 7'h13),
            op_r(7'h00, 5'd7, 5'd7, 3'b000, 5'd8),
            op_i(32'hFFF, 5'd0, 3'b011, 5'd9, 7'h13),
            op_i(32'h0F0, 5'd1, 3'b100, 5'd10, 7'h13),
            op_r(7'h20, 5'd2, 5'd7, 3'b101, 5'd11),
            ECALL};
    start();
    run_to_ecall(50);
    chk("t3_sltu", dut.i_regfile.data[2], 32'd1);
    chk("t3_slt", dut.i_regfile.data[3], 32'd1);
    chk("t3_srai", dut.i_regfile.data[4], 32'hFFFF_FFFF);
    chk("t3_srli", dut.i_regfile.data[5], 32'h0FFF_FFFF);
    chk("t3_sub", dut.i_regfile.data[6], 32'd1);
    chk("t3_slli", dut.i_regfile.data[7], 32'h8000_0000);
    chk("t3_add_wrap", dut.i_regfile.data[8], 32'd0);
    chk("t3_sltiu", dut.i_regfile.data[9], 32'd1);
    chk("t3_xori", dut.i_regfile.data[10], 32'hFFFF_FF0F);
    chk("t3_sra", dut.i_regfile.data[11], 32'hC000_0000);

    // control flow, x0, CSR, FENCE/EBREAK as NOP
    prog = {op_i(32'd7, 5'd0, 3'b000, 5'd3, 7'h13),
            op_b(32'd8, 5'd0, 5'd0, 3'b000),
            op_i(32'd2, 5'd0, 3'b000, 5'd3, 7'h13),
            op_j(32'd8, 5'd5),
            op_i(32'd3, 5'd0, 3'b000, 5'd3, 7'h13),
            op_i(32'd5, 5'd0, 3'b000, 5'd0, 7'h13),
            op_b(32'd8, 5'd0, 5'd0, 3'b001),
            op_u(20'h00001, 5'd6, 7'h17),
            op_u(20'h00000, 5'd7, 7'h17),
            op_i(32'd13, 5'd7, 3'b000, 5'd7, 7'h67),
            op_i(32'd4, 5'd0, 3'b000, 5'd3, 7'h13),
            op_i(32'hFFF, 5'd0, 3'b000, 5'd8, 7'h13),
            op_b(32'd8, 5'd8, 5'd0, 3'b110),
            op_i(32'd5, 5'd0, 3'b000, 5'd3, 7'h13),
            op_i(32'd9, 5'd0, 3'b000, 5'd9, 7'h13),
            op_b(32'd8, 5'd0, 5'd8, 3'b101),
            op_i(32'h300, 5'd8, 3'b001, 5'd9, 7'h73),
            32'h0000_000F,
            32'h0010_0073,
            ECALL};
    start();
    run_to_ecall(60);
    chk("t4_x0", dut.i_regfile.rdata1 & 32'd0 | dut.i_regfile.data[0], 32'd0);
    chk("t4_x3_skipped", dut.i_regfile.data[3], 32'd7);
    chk("t4_jal_link", dut.i_regfile.data[5], 32'h8000_0010);
    chk("t4_auipc", dut.i_regfile.data[6], 32'h8000_101C);
    chk("t4_jalr_rd_rs1", dut.i_regfile.data[7], 32'h8000_0028);
    chk("t4_x8", dut.i_regfile.data[8], 32'hFFFF_FFFF);
    chk("t4_csr_rd0", dut.i_regfile.data[9], 32'd0);
    chk("t4_pc_end", dut.pc, 32'h8000_004C);

    // reset mid-program: state persists, writes during reset discarded
    prog = {op_i(32'h010, 5'd12, 3'b000, 5'd12, 7'h13),
            op_s(32'h200, 5'd12, 5'd0, 3'b010),
            op_i(32'h066, 5'd0, 3'b000, 5'd13, 7'h13),
            ECALL};
    @(negedge clk);
    rst = 1'b1;
    dut.i_regfile.data[12] = 32'h100;
    start();
    repeat (3) @(negedge clk);
    chk("t5_pc_pre", dut.pc, 32'h8000_000C);
    rst = 1'b1;
    #1;
    chk("t5_pc_async", dut.pc, RPC);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_x12_kept", dut.i_regfile.data[12], 32'h110);
    chk("t5_x13_kept", dut.i_regfile.data[13], 32'h66);
    chk("t5_mem_kept", dut.mem[128], 32'h110);
    chk("t5_pc_post", dut.pc, RPC);
    run_to_ecall(20);
    chk("t5_x12_rerun", dut.i_regfile.data[12], 32'h120);
    chk("t5_mem_rerun", dut.mem[128], 32'h120);

`ifdef RV32I_CORE_HALT_EN
    prog = {op_i(32'd1, 5'd0, 3'b000, 5'd14, 7'h13),
            op_i(32'd1, 5'd14, 3'b000, 5'd14, 7'h13),
            op_s(32'h300, 5'd14, 5'd0, 3'b010),
            ECALL};
    start();
    @(negedge clk);
    halt = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_halt_pc", dut.pc, 32'h8000_0004);
    chk("t6_halt_x14", dut.i_regfile.data[14], 32'd1);
    chk("t6_halt_mem", dut.mem[192], ECALL);
    halt = 1'b0;
    run_to_ecall(20);
    chk("t6_resume_x14", dut.i_regfile.data[14], 32'd2);
    chk("t6_resume_mem", dut.mem[192], 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
